sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised sprite compositor for the VGA display path. It holds NUM_SPRITES host-programmable sprite slots, each double-buffered, with the shadow copy committed at frame start. Every pixel it fetches per-slot sprite ROM data, merges opaque sprite pixels over a supplied background colour index by fixed priority, and accumulates per-slot collision flags. It sits between the VGA counters/background generator and the palette/RGB stage. Unlike the previous renderer, it adds a variable slot count, horizontal flip, tear-free register update, collision status and a registered read port.

## Interface
Parameters:
- NUM_SPRITES, 4: slot count, 1..15.
- SPRITE_SIZE, 32: sprite edge in pixels, power of 2; S = log2(SPRITE_SIZE).
- IMG_W, 5: image-select width.
- COORD_W, 10: pixel coordinate width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  6  register word address.
- writedata  in  16  write data.
- readdata  out  16  read data, read latency 1.
- hcol  in  COORD_W  current pixel column.
- vrow  in  COORD_W  current pixel row.
- pix_en  in  1  hcol/vrow/bg_color valid this cycle.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- bg_color  in  4  background colour index for hcol/vrow.
- rom_addr  out  NUM_SPRITES*(IMG_W+2S)  per slot {img,row,col}; slot i at bits [i*(IMG_W+2S) +: IMG_W+2S].
- rom_data  in  NUM_SPRITES*4  per-slot colour index, valid 1 cycle after rom_addr; 0 = transparent.
- pix_color  out  4  composited colour index.
- pix_valid  out  1  pix_color valid.
- collision_irq  out  1  level interrupt.

## Operation
- Register map (word addresses):
  - slot i base 4i, +0: x[COORD_W-1:0].
  - +1: y[COORD_W-1:0].
  - +2: img[IMG_W-1:0], enable = bit 8, hflip = bit 9.
  - +3: reserved; writes ignored, reads 0.
  - 60: irq_en (bit 0), R/W.
  - 62: collision status, NUM_SPRITES bits, read-only.
  - 63: read returns 16'h5C01.
  - Unmapped addresses read 0.
- x and y give the sprite's top-left corner; there is no centre offset.
- Host writes go to the shadow registers. Each slot's shadow is copied to its active register on frame_start.
- Hit for slot i: active enable=1, x ≤ hcol < x+SPRITE_SIZE and y ≤ vrow < y+SPRITE_SIZE.
  - Compares are done in COORD_W+1 bits, so x+SPRITE_SIZE never wraps.
  - A sprite at x = 2^COORD_W−1 covers only that single column.
- Address generation:
  - col = hcol−x, or SPRITE_SIZE−1−(hcol−x) when hflip=1; row = vrow−y; both truncated to S bits.
  - rom_addr slot field = {img, row, col}. When not hit, the field is driven 0.
- Compositing: the lowest-index slot with hit and rom_data≠0 wins; if no slot wins, output bg_color.
- Collision:
  - When two or more slots are hit-and-opaque on the same pixel, set accumulator bit for every such slot.
  - On frame_start, status ← accumulator and accumulator ← 0.
- collision_irq = irq_en & (status≠0).

## Timing
- Pipeline advances every clk, with no stall.
  - Stage 1 registers hit, rom_addr, bg_color and valid.
  - Stage 2 samples rom_data and resolves priority and collision.
  - Stage 3 registers pix_color and pix_valid.
- pix_valid is pix_en delayed 3 cycles; pix_color belongs to the hcol/vrow presented 3 cycles earlier.
- Register write takes effect in shadow on the clock edge where chipselect&write is high.
- readdata updates the cycle after chipselect&read; it holds its value otherwise.
- Simultaneous events:
  - Shadow write in the same cycle as frame_start: active takes the pre-write value; the new value goes live at the next frame_start.
  - Status read in the same cycle as frame_start: returns the pre-update status.
  - A collision on the same cycle as frame_start is counted in the new accumulator.
- Reset, at any time including mid-frame, immediately clears all of the following to 0:
  - shadow and active registers (all slots disabled), irq_en, status, accumulator;
  - pipeline valids, pix_color, pix_valid, rom_addr, readdata, collision_irq.

## Test plan
- Slot 0 write x=100, y=50, img=1, enable=1, then pulse frame_start. Scan row 50 with rom_data=4 everywhere → pix_color=4 for hcol 100..131 and bg_color elsewhere; pix_valid exactly 3 cycles after each pix_en.
- Program slot 0 enabled but no frame_start → background only. Write x again in the same cycle as frame_start → old x rendered this frame, new x next frame.
- Slot 0 with hflip=1, x=10, hcol=10 → rom_addr col field = 31. With hflip=0 → col field = 0.
- Slots 1 and 2 overlapping at (200,100), both with rom_data≠0, irq_en=1 → slot 1 colour shown. After frame_start, read addr 62 = 4'b0110, collision_irq=1. Next frame with no overlap → status 0, irq=0.
- Slot 0 rom_data=0 over an opaque slot 3 → slot 3 colour shown and no collision bit set. Slot at x=1023 → hit only at hcol=1023.
- Assert reset mid-line with pix_valid high → all outputs 0 in the same cycle; after release, all slots disabled and addr 63 reads 16'h5C01.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite compositor: NUM_SPRITES double-buffered sprite slots merged over a
// background colour index, with per-slot collision status and a
// registered Avalon read port. Three-cycle pixel pipeline, no stall.

// One sprite slot: shadow/active registers, hit test and ROM address stage.
module sprite_slot #(
    parameter int SPRITE_SIZE = 32,
    parameter int IMG_W       = 5,
    parameter int COORD_W     = 10,
    parameter int S           = $clog2(SPRITE_SIZE),
    parameter int AW          = IMG_W + 2*S
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_x,
    input  logic               wr_y,
    input  logic               wr_ctl,
    input  logic [15:0]        wdata,
    input  logic               frame_start,
    input  logic               pix_en,
    input  logic [COORD_W-1:0] hcol,
    input  logic [COORD_W-1:0] vrow,
    output logic [15:0]        rd_x,
    output logic [15:0]        rd_y,
    output logic [15:0]        rd_ctl,
    output logic               hit_q,
    output logic [AW-1:0]      addr_q
);
    logic [COORD_W-1:0] sh_x, sh_y, ac_x, ac_y;
    logic [IMG_W-1:0]   sh_img, ac_img;
    logic               sh_en, sh_flip, ac_en, ac_flip;

    logic [COORD_W:0]   hc_e, vr_e, x_e, y_e;
    logic [COORD_W-1:0] dx, dy;
    logic [S-1:0]       col, row;
    logic               in_x, in_y, hit;
    logic               unused_bits;

    // Host writes land in the shadow copy only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x    <= '0;
            sh_y    <= '0;
            sh_img  <= '0;
            sh_en   <= 1'b0;
            sh_flip <= 1'b0;
        end else begin
            if (wr_x) sh_x <= wdata[COORD_W-1:0];
            if (wr_y) sh_y <= wdata[COORD_W-1:0];
            if (wr_ctl) begin
                sh_img  <= wdata[IMG_W-1:0];
                sh_en   <= wdata[8];
                sh_flip <= wdata[9];
            end
        end
    end

    // Shadow goes live at frame start; a same-edge write misses this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac_x    <= '0;
            ac_y    <= '0;
            ac_img  <= '0;
            ac_en   <= 1'b0;
            ac_flip <= 1'b0;
        end else if (frame_start) begin
            ac_x    <= sh_x;
            ac_y    <= sh_y;
            ac_img  <= sh_img;
            ac_en   <= sh_en;
            ac_flip <= sh_flip;
        end
    end

    // Hit test in COORD_W+1 bits so x+SPRITE_SIZE cannot wrap; ROM address.
    always_comb begin
        hc_e = {1'b0, hcol};
        vr_e = {1'b0, vrow};
        x_e  = {1'b0, ac_x};
        y_e  = {1'b0, ac_y};
        in_x = (hc_e >= x_e) && (hc_e < x_e + (COORD_W+1)'(SPRITE_SIZE));
        in_y = (vr_e >= y_e) && (vr_e < y_e + (COORD_W+1)'(SPRITE_SIZE));
        hit  = pix_en & ac_en & in_x & in_y;
        dx   = hcol - ac_x;
        dy   = vrow - ac_y;
        // SPRITE_SIZE-1-n over S bits is just the bitwise inverse.
        col  = ac_flip ? ~dx[S-1:0] : dx[S-1:0];
        row  = dy[S-1:0];
    end

    // Stage 1: register hit and the slot's ROM address (zero when not hit).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit;
            addr_q <= hit ? {ac_img, row, col} : '0;
        end
    end

    // Read-back view of the shadow registers.
    always_comb begin
        rd_x            = '0;
        rd_y            = '0;
        rd_ctl          = '0;
        rd_x[COORD_W-1:0] = sh_x;
        rd_y[COORD_W-1:0] = sh_y;
        rd_ctl[IMG_W-1:0] = sh_img;
        rd_ctl[8]       = sh_en;
        rd_ctl[9]       = sh_flip;
    end

    assign unused_bits = ^{wdata, dx, dy};
endmodule

module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 32,
    parameter int IMG_W       = 5,
    parameter int COORD_W     = 10,
    parameter int S           = $clog2(SPRITE_SIZE),
    parameter int AW          = IMG_W + 2*S
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic                      read,
    input  logic [5:0]                address,
    input  logic [15:0]               writedata,
    output logic [15:0]               readdata,
    input  logic [COORD_W-1:0]        hcol,
    input  logic [COORD_W-1:0]        vrow,
    input  logic                      pix_en,
    input  logic                      frame_start,
    input  logic [3:0]                bg_color,
    output logic [NUM_SPRITES*AW-1:0] rom_addr,
    input  logic [NUM_SPRITES*4-1:0]  rom_data,
    output logic [3:0]                pix_color,
    output logic                      pix_valid,
    output logic                      collision_irq
);
    localparam int STAGES = 3;

    logic                   wr_stb, rd_stb;
    logic [3:0]             slot_sel;
    logic [NUM_SPRITES-1:0] wr_x, wr_y, wr_ctl;
    logic [15:0]            rd_x   [NUM_SPRITES];
    logic [15:0]            rd_y   [NUM_SPRITES];
    logic [15:0]            rd_ctl [NUM_SPRITES];
    logic [15:0]            rd_mux;

    logic [NUM_SPRITES-1:0] hit1, hit2, opq;
    logic [3:0]             bg1, bg2, color;
    logic [STAGES:1]        vld_pipe;
    logic [4:0]             n_opq;
    logic                   collide;
    logic [NUM_SPRITES-1:0] coll_now, acc, status;
    logic                   irq_en;

    assign wr_stb   = chipselect & write;
    assign rd_stb   = chipselect & read;
    assign slot_sel = address[5:2];

    // Per-slot write strobes from the word address.
    always_comb begin
        wr_x   = '0;
        wr_y   = '0;
        wr_ctl = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_stb && slot_sel == 4'(i)) begin
                wr_x[i]   = (address[1:0] == 2'd0);
                wr_y[i]   = (address[1:0] == 2'd1);
                wr_ctl[i] = (address[1:0] == 2'd2);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_slot
            sprite_slot #(
                .SPRITE_SIZE (SPRITE_SIZE),
                .IMG_W       (IMG_W),
                .COORD_W     (COORD_W)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .wr_x        (wr_x[g]),
                .wr_y        (wr_y[g]),
                .wr_ctl      (wr_ctl[g]),
                .wdata       (writedata),
                .frame_start (frame_start),
                .pix_en      (pix_en),
                .hcol        (hcol),
                .vrow        (vrow),
                .rd_x        (rd_x[g]),
                .rd_y        (rd_y[g]),
                .rd_ctl      (rd_ctl[g]),
                .hit_q       (hit1[g]),
                .addr_q      (rom_addr[g*AW +: AW])
            );
        end
    endgenerate

    // irq enable register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              irq_en <= 1'b0;
        else if (wr_stb && address == 6'd60)    irq_en <= writedata[0];
    end

    // Read mux; slot offset 3 and unmapped words read 0.
    always_comb begin
        rd_mux = '0;
        case (address)
            6'd60:   rd_mux[0] = irq_en;
            6'd62:   rd_mux[NUM_SPRITES-1:0] = status;
            6'd63:   rd_mux = 16'h5C01;
            default: begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (slot_sel == 4'(i)) begin
                        case (address[1:0])
                            2'd0:    rd_mux = rd_x[i];
                            2'd1:    rd_mux = rd_y[i];
                            2'd2:    rd_mux = rd_ctl[i];
                            default: rd_mux = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Registered read port: updates on a read, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       readdata <= '0;
        else if (rd_stb) readdata <= rd_mux;
    end

    // Valid shift register and stage-1 background capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            bg1      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_en};
            bg1      <= bg_color;
        end
    end

    // Stage 2: align hits and background with the returning ROM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit2 <= '0;
            bg2  <= '0;
        end else begin
            hit2 <= hit1;
            bg2  <= bg_color_d(bg1);
        end
    end

    function automatic logic [3:0] bg_color_d(input logic [3:0] b);
        return b;
    endfunction

    // Priority resolve: lowest opaque slot wins; count opaque hits.
    always_comb begin
        color = bg2;
        n_opq = '0;
        opq   = '0;
        for (int i = NUM_SPRITES-1; i >= 0; i--) begin
            opq[i] = hit2[i] & (rom_data[i*4 +: 4] != 4'd0);
            if (opq[i]) color = rom_data[i*4 +: 4];
            n_opq = n_opq + 5'(opq[i]);
        end
        collide  = (n_opq >= 5'd2);
        coll_now = collide ? opq : '0;
    end

    // Stage 3: composited output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix_color <= '0;
        else       pix_color <= color;
    end

    assign pix_valid = vld_pipe[STAGES];

    // Collision accumulate; frame start publishes it and restarts with any
    // collision landing on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            status <= '0;
        end else if (frame_start) begin
            acc    <= coll_now;
            status <= acc;
        end else begin
            acc    <= acc | coll_now;
        end
    end

    assign collision_irq = irq_en & (status != '0);
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: register access, priority
// compositing, flip addressing, double buffering, collision status, reset.
module tb_sprite_compositor;
    localparam int N  = 4;
    localparam int AW = 15;

    logic          clk, reset, chipselect, write, read, pix_en, frame_start;
    logic [5:0]    address;
    logic [15:0]   writedata, readdata;
    logic [9:0]    hcol, vrow;
    logic [3:0]    bg_color, pix_color;
    logic [N*AW-1:0] rom_addr;
    logic [N*4-1:0]  rom_data;
    logic          pix_valid, collision_irq;

    int n_chk = 0;
    int n_fail = 0;

    sprite_compositor dut (
        .clk (clk), .reset (reset), .chipselect (chipselect), .write (write),
        .read (read), .address (address), .writedata (writedata),
        .readdata (readdata), .hcol (hcol), .vrow (vrow), .pix_en (pix_en),
        .frame_start (frame_start), .bg_color (bg_color), .rom_addr (rom_addr),
        .rom_data (rom_data), .pix_color (pix_color), .pix_valid (pix_valid),
        .collision_irq (collision_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int h; int v; int bg; int exp; } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        chipselect = 1; write = 1; address = 6'(a); writedata = 16'(d);
        tick();
        chipselect = 0; write = 0;
    endtask

    task automatic rd(input int a, output int d);
        chipselect = 1; read = 1; address = 6'(a);
        tick();
        chipselect = 0; read = 0;
        d = int'(readdata);
    endtask

    task automatic frame();
        frame_start = 1; tick(); frame_start = 0;
    endtask

    // One pixel through the pipe: valid must appear exactly 3 cycles later.
    task automatic pix_chk(input string nm, input int h, input int v, input int bg, input int exp);
        hcol = 10'(h); vrow = 10'(v); bg_color = 4'(bg); pix_en = 1;
        tick();
        pix_en = 0; bg_color = 4'd15;
        chk({nm, " valid@1"}, int'(pix_valid), 0);
        tick();
        chk({nm, " valid@2"}, int'(pix_valid), 0);
        tick();
        chk({nm, " valid@3"}, int'(pix_valid), 1);
        chk({nm, " color"}, int'(pix_color), exp);
    endtask

    // ROM address of one slot, one cycle after the pixel is presented.
    task automatic addr_chk(input string nm, input int slot, input int h, input int v, input int exp);
        hcol = 10'(h); vrow = 10'(v); pix_en = 1;
        tick();
        pix_en = 0;
        chk(nm, int'((rom_addr >> (slot*AW)) & 60'h7FFF), exp);
        tick(); tick();
    endtask

    initial begin
        int d;
        reset = 1; chipselect = 0; write = 0; read = 0; address = '0;
        writedata = '0; hcol = '0; vrow = '0; pix_en = 0; frame_start = 0;
        bg_color = '0; rom_data = '0;
        tick(); tick();
        chk("rst pix_valid", int'(pix_valid), 0);
        chk("rst pix_color", int'(pix_color), 0);
        chk("rst rom_addr", int'(rom_addr != '0), 0);
        chk("rst readdata", int'(readdata), 0);
        chk("rst irq", int'(collision_irq), 0);
        reset = 0;
        tick();

        rd(63, d); chk("id reg", d, 16'h5C01);
        rd(3, d);  chk("reserved", d, 0);
        rd(50, d); chk("unmapped", d, 0);

        // Slot 0 programmed but not committed: background only.
        wr(0, 100); wr(1, 50); wr(2, 16'h101);
        rd(0, d); chk("shadow x readback", d, 100);
        rd(2, d); chk("shadow ctl readback", d, 16'h101);
        rom_data = 16'h4444;
        pix_chk("uncommitted", 100, 50, 7, 7);
        frame();

        tbl[0] = '{99, 50, 7, 7};
        tbl[1] = '{100, 50, 7, 4};
        tbl[2] = '{115, 50, 7, 4};
        tbl[3] = '{131, 50, 7, 4};
        tbl[4] = '{132, 50, 7, 7};
        tbl[5] = '{100, 49, 3, 3};
        tbl[6] = '{100, 81, 3, 4};
        tbl[7] = '{100, 82, 3, 3};
        for (int i = 0; i < 8; i++)
            pix_chk($sformatf("scan[%0d]", i), tbl[i].h, tbl[i].v, tbl[i].bg, tbl[i].exp);

        // Write x on the frame_start edge: old x this frame, new x next.
        chipselect = 1; write = 1; address = 6'd0; writedata = 16'd200; frame_start = 1;
        tick();
        chipselect = 0; write = 0; frame_start = 0;
        pix_chk("same-edge old x", 100, 50, 7, 4);
        pix_chk("same-edge new x idle", 200, 50, 7, 7);
        frame();
        pix_chk("next frame new x", 200, 50, 7, 4);
        pix_chk("next frame old x gone", 100, 50, 7, 7);

        // Horizontal flip addressing, img=1.
        wr(0, 10); wr(2, 16'h301); frame();
        addr_chk("hflip col31", 0, 10, 50, 1024 + 31);
        addr_chk("hflip col29 row3", 0, 12, 53, 1024 + 96 + 29);
        wr(2, 16'h101); frame();
        addr_chk("noflip col0", 0, 10, 50, 1024);
        addr_chk("noflip col31", 0, 41, 50, 1024 + 31);
        addr_chk("miss addr 0", 0, 42, 50, 0);

        // Collision between slots 1 and 2.
        wr(2, 0);
        wr(4, 200); wr(5, 100); wr(6, 16'h102);
        wr(8, 200); wr(9, 100); wr(10, 16'h103);
        wr(60, 1);
        frame();
        rom_data = 16'h0650;
        pix_chk("overlap prio", 210, 110, 3, 5);
        chk("irq before frame", int'(collision_irq), 0);
        chipselect = 1; read = 1; address = 6'd62; frame_start = 1;
        tick();
        chipselect = 0; read = 0; frame_start = 0;
        chk("status read on frame edge", int'(readdata), 0);
        chk("irq after frame", int'(collision_irq), 1);
        rd(62, d); chk("status", d, 6);

        // Collision landing on the frame_start edge goes to the new accumulator.
        hcol = 10'd210; vrow = 10'd110; pix_en = 1;
        tick();
        pix_en = 0;
        tick();
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("irq cleared", int'(collision_irq), 0);
        rd(62, d); chk("status after empty frame", d, 0);
        frame();
        rd(62, d); chk("status carried collision", d, 6);

        wr(8, 400); frame();
        pix_chk("slot1 alone", 210, 110, 3, 5);
        pix_chk("slot2 alone", 400, 100, 3, 6);
        frame();
        rd(62, d); chk("status no overlap", d, 0);
        chk("irq no overlap", int'(collision_irq), 0);

        // Transparent slot 0 over opaque slot 3.
        wr(6, 0); wr(10, 0);
        wr(0, 200); wr(1, 100); wr(2, 16'h101);
        wr(12, 200); wr(13, 100); wr(14, 16'h104);
        frame();
        rom_data = 16'h9000;
        pix_chk("transparent over", 205, 105, 2, 9);
        frame();
        rd(62, d); chk("no collision on transparent", d, 0);

        // Right-edge sprite covers only the last column.
        wr(12, 1023); frame();
        pix_chk("edge 1022", 1022, 100, 2, 2);
        pix_chk("edge 1023", 1023, 100, 2, 9);
        pix_chk("edge wrap 0", 0, 100, 2, 2);
        pix_chk("edge row 131", 1023, 131, 2, 9);
        pix_chk("edge row 132", 1023, 132, 2, 2);

        // Reset mid-line with the pipe full.
        rd(63, d);
        hcol = 10'd1023; vrow = 10'd100; bg_color = 4'd2; pix_en = 1;
        tick(); tick(); tick(); tick();
        chk("pre-reset valid", int'(pix_valid), 1);
        chk("pre-reset color", int'(pix_color), 9);
        chk("pre-reset addr", int'((rom_addr >> (3*AW)) & 60'h7FFF), 4096);
        #2 reset = 1;
        #1;
        chk("mid rst pix_valid", int'(pix_valid), 0);
        chk("mid rst pix_color", int'(pix_color), 0);
        chk("mid rst rom_addr", int'(rom_addr != '0), 0);
        chk("mid rst readdata", int'(readdata), 0);
        chk("mid rst irq", int'(collision_irq), 0);
        pix_en = 0;
        tick();
        reset = 0;
        tick();
        rd(63, d); chk("post rst id", d, 16'h5C01);
        rd(14, d); chk("post rst ctl", d, 0);
        rd(60, d); chk("post rst irq_en", d, 0);
        frame();
        pix_chk("post rst disabled", 1023, 100, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
